// File: rtl/ex_stage_mul_if.sv
// ============================================================================
//  ex_stage_mul_if
//  ID/EX inputs, MEM/WB forwarding sources and EX/MEM outputs of ex_stage_mul.
//  Revision: 1.0
// ============================================================================
`default_nettype none

interface ex_stage_mul_if #(
    parameter int DATA_W = 32
);
    logic [1:0]        EX_wb;
    logic [1:0]        EX_m;
    logic              EX_alu_src;
    logic [1:0]        EX_alu_op;
    logic              EX_reg_dst;
    logic [DATA_W-1:0] EX_reg_data1;
    logic [DATA_W-1:0] EX_reg_data2;
    logic [DATA_W-1:0] EX_sign_ext_imm;
    logic [4:0]        EX_instr_25_21;
    logic [4:0]        EX_instr_20_16;
    logic [4:0]        EX_instr_15_11;
    logic              MEM_fwd_reg_write;
    logic              WB_fwd_reg_write;
    logic [4:0]        MEM_fwd_rd;
    logic [4:0]        WB_fwd_rd;
    logic [DATA_W-1:0] MEM_fwd_data;
    logic [DATA_W-1:0] WB_fwd_data;
    logic              ex_stall;
    logic [1:0]        MEM_wb;
    logic [1:0]        MEM_m;
    logic [DATA_W-1:0] MEM_alu_result;
    logic [DATA_W-1:0] MEM_write_data;
    logic [4:0]        MEM_dst;
    logic              MEM_zero;

    modport slave (
        input  EX_wb, EX_m, EX_alu_src, EX_alu_op, EX_reg_dst,
        input  EX_reg_data1, EX_reg_data2, EX_sign_ext_imm,
        input  EX_instr_25_21, EX_instr_20_16, EX_instr_15_11,
        input  MEM_fwd_reg_write, WB_fwd_reg_write, MEM_fwd_rd, WB_fwd_rd,
        input  MEM_fwd_data, WB_fwd_data,
        output ex_stall, MEM_wb, MEM_m, MEM_alu_result, MEM_write_data,
        output MEM_dst, MEM_zero
    );

    modport master (
        output EX_wb, EX_m, EX_alu_src, EX_alu_op, EX_reg_dst,
        output EX_reg_data1, EX_reg_data2, EX_sign_ext_imm,
        output EX_instr_25_21, EX_instr_20_16, EX_instr_15_11,
        output MEM_fwd_reg_write, WB_fwd_reg_write, MEM_fwd_rd, WB_fwd_rd,
        output MEM_fwd_data, WB_fwd_data,
        input  ex_stall, MEM_wb, MEM_m, MEM_alu_result, MEM_write_data,
        input  MEM_dst, MEM_zero
    );
endinterface

`default_nettype wire

// File: rtl/ex_stage_mul.sv
// ============================================================================
//  ex_stage_mul
//  Execute stage: forwarding, ALU, iterative shift-add MUL, EX/MEM register.
//  Optional macro EX_FORWARD_EN enables MEM/WB operand forwarding.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module ex_stage_mul #(
    parameter int DATA_W   = 32,
    parameter int MUL_BITS = 1
) (
    input  wire logic        clk,
    input  wire logic        startin_n,
    ex_stage_mul_if.slave    bus
);
    localparam int STEPS = DATA_W / MUL_BITS;
    localparam int CNT_W = (STEPS > 1) ? $clog2(STEPS) : 1;
    localparam logic [CNT_W-1:0] C_LAST = CNT_W'(STEPS - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]        r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic [DATA_W-1:0] r_acc, r_mcand, r_mplier, r_hold_b;
    logic [1:0]        r_hold_wb, r_hold_m;
    logic [4:0]        r_hold_dst;
    logic [1:0]        r_mem_wb, r_mem_m;
    logic [DATA_W-1:0] r_mem_res, r_mem_wd;
    logic [4:0]        r_mem_dst;
    logic              r_mem_zero;

    logic [DATA_W-1:0] w_fwd_a, w_fwd_b, w_op_b, w_alu_res, w_partial;
    logic [5:0]        w_funct;
    logic [4:0]        w_dst;
    logic              w_is_mul, w_slt;

`ifdef EX_FORWARD_EN
    // WB assigned first so a matching MEM source overrides it.
    always_comb begin
        w_fwd_a = bus.EX_reg_data1;
        w_fwd_b = bus.EX_reg_data2;
        if (bus.WB_fwd_reg_write && bus.WB_fwd_rd != 5'd0 && bus.WB_fwd_rd == bus.EX_instr_25_21)
            w_fwd_a = bus.WB_fwd_data;
        if (bus.MEM_fwd_reg_write && bus.MEM_fwd_rd != 5'd0 && bus.MEM_fwd_rd == bus.EX_instr_25_21)
            w_fwd_a = bus.MEM_fwd_data;
        if (bus.WB_fwd_reg_write && bus.WB_fwd_rd != 5'd0 && bus.WB_fwd_rd == bus.EX_instr_20_16)
            w_fwd_b = bus.WB_fwd_data;
        if (bus.MEM_fwd_reg_write && bus.MEM_fwd_rd != 5'd0 && bus.MEM_fwd_rd == bus.EX_instr_20_16)
            w_fwd_b = bus.MEM_fwd_data;
    end
`else
    logic w_unused_fwd;
    assign w_fwd_a      = bus.EX_reg_data1;
    assign w_fwd_b      = bus.EX_reg_data2;
    assign w_unused_fwd = ^{bus.MEM_fwd_reg_write, bus.WB_fwd_reg_write, bus.MEM_fwd_rd,
                            bus.WB_fwd_rd, bus.MEM_fwd_data, bus.WB_fwd_data, bus.EX_instr_25_21};
`endif

    assign w_op_b   = bus.EX_alu_src ? bus.EX_sign_ext_imm : w_fwd_b;
    assign w_funct  = bus.EX_sign_ext_imm[5:0];
    assign w_is_mul = (bus.EX_alu_op == 2'b10) && (w_funct == 6'h18);
    assign w_dst    = bus.EX_reg_dst ? bus.EX_instr_15_11 : bus.EX_instr_20_16;
    assign w_slt    = $signed(w_fwd_a) < $signed(w_op_b);

    always_comb begin
        w_alu_res = '0;
        case (bus.EX_alu_op)
            2'b00: w_alu_res = w_fwd_a + w_op_b;
            2'b01: w_alu_res = w_fwd_a - w_op_b;
            2'b11: w_alu_res = w_fwd_a | w_op_b;
            default: begin
                case (w_funct)
                    6'h20:   w_alu_res = w_fwd_a + w_op_b;
                    6'h22:   w_alu_res = w_fwd_a - w_op_b;
                    6'h24:   w_alu_res = w_fwd_a & w_op_b;
                    6'h25:   w_alu_res = w_fwd_a | w_op_b;
                    6'h2A:   w_alu_res = {{(DATA_W-1){1'b0}}, w_slt};
                    default: w_alu_res = '0;
                endcase
            end
        endcase
    end

    // One shift-add step: the low MUL_BITS multiplier bits scale the shifted multiplicand.
    assign w_partial = r_mcand * DATA_W'(r_mplier[MUL_BITS-1:0]);

    // Reset gates the IDLE-decode term so a held MUL does not assert stall during reset.
    assign bus.ex_stall = (r_state == S_BUSY) || ((r_state == S_IDLE) && w_is_mul && startin_n);

    always_ff @(posedge clk) begin
        if (!startin_n) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_acc      <= '0;
            r_mcand    <= '0;
            r_mplier   <= '0;
            r_hold_b   <= '0;
            r_hold_wb  <= '0;
            r_hold_m   <= '0;
            r_hold_dst <= '0;
            r_mem_wb   <= '0;
            r_mem_m    <= '0;
            r_mem_res  <= '0;
            r_mem_wd   <= '0;
            r_mem_dst  <= '0;
            r_mem_zero <= 1'b0;
        end else begin
            r_mem_wb   <= '0;
            r_mem_m    <= '0;
            r_mem_res  <= '0;
            r_mem_wd   <= '0;
            r_mem_dst  <= '0;
            r_mem_zero <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_is_mul) begin
                        r_mcand    <= w_fwd_a;
                        r_mplier   <= w_op_b;
                        r_hold_b   <= w_fwd_b;
                        r_hold_wb  <= bus.EX_wb;
                        r_hold_m   <= bus.EX_m;
                        r_hold_dst <= w_dst;
                        r_acc      <= '0;
                        r_cnt      <= '0;
                        r_state    <= S_BUSY;
                    end else begin
                        r_mem_wb   <= bus.EX_wb;
                        r_mem_m    <= bus.EX_m;
                        r_mem_res  <= w_alu_res;
                        r_mem_wd   <= w_fwd_b;
                        r_mem_dst  <= w_dst;
                        r_mem_zero <= (w_alu_res == '0);
                    end
                end
                S_BUSY: begin
                    r_acc    <= r_acc + w_partial;
                    r_mcand  <= r_mcand << MUL_BITS;
                    r_mplier <= r_mplier >> MUL_BITS;
                    r_cnt    <= r_cnt + 1'b1;
                    if (r_cnt == C_LAST)
                        r_state <= S_DONE;
                end
                S_DONE: begin
                    r_mem_wb   <= r_hold_wb;
                    r_mem_m    <= r_hold_m;
                    r_mem_res  <= r_acc;
                    r_mem_wd   <= r_hold_b;
                    r_mem_dst  <= r_hold_dst;
                    r_mem_zero <= (r_acc == '0);
                    r_state    <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.MEM_wb         = r_mem_wb;
    assign bus.MEM_m          = r_mem_m;
    assign bus.MEM_alu_result = r_mem_res;
    assign bus.MEM_write_data = r_mem_wd;
    assign bus.MEM_dst        = r_mem_dst;
    assign bus.MEM_zero       = r_mem_zero;

endmodule

`default_nettype wire

// File: tb/tb_ex_stage_mul.sv
// ============================================================================
//  tb_ex_stage_mul
//  Directed bench for ex_stage_mul against an instruction-level model.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module tb_ex_stage_mul;
    localparam int DATA_W   = 32;
    localparam int MUL_BITS = 1;
    localparam int STEPS    = DATA_W / MUL_BITS;

    typedef struct packed {
        logic [1:0]  wb, m;
        logic        alu_src;
        logic [1:0]  alu_op;
        logic        reg_dst;
        logic [31:0] d1, d2, imm;
        logic [4:0]  rs, rt, rd;
        logic        mem_we, wb_we;
        logic [4:0]  mem_rd, wb_rd;
        logic [31:0] mem_data, wb_data;
    } instr_t;

    typedef struct packed {
        logic [1:0]  wb, m;
        logic [31:0] res, wd;
        logic [4:0]  dst;
        logic        zero;
    } exp_t;

    logic clk = 1'b0;
    logic startin_n = 1'b0;
    always #5 clk = ~clk;

    ex_stage_mul_if #(.DATA_W(DATA_W)) bus ();

    ex_stage_mul #(.DATA_W(DATA_W), .MUL_BITS(MUL_BITS)) dut (
        .clk       (clk),
        .startin_n (startin_n),
        .bus       (bus)
    );

    exp_t        exp_q = '0;
    logic        exp_stall = 1'b0;
    logic        chk_en = 1'b0;
    int          n_cmp = 0;
    int          n_err = 0;
    int          lit_seq = 0;
    int          lit_done = 0;
    string       lit_name = "";
    logic [31:0] lit_res = '0;
    logic        lit_zero = 1'b0;

    function automatic logic is_mul(instr_t t);
        return t.alu_op == 2'b10 && t.imm[5:0] == 6'h18;
    endfunction

    // Instruction-level reference: forwarding choice, then plain arithmetic.
    function automatic exp_t model(instr_t t);
        exp_t        e;
        logic [31:0] a, b, ob, r;
        a = t.d1;
        b = t.d2;
`ifdef EX_FORWARD_EN
        if (t.mem_we && t.mem_rd != 0 && t.mem_rd == t.rs)     a = t.mem_data;
        else if (t.wb_we && t.wb_rd != 0 && t.wb_rd == t.rs)   a = t.wb_data;
        if (t.mem_we && t.mem_rd != 0 && t.mem_rd == t.rt)     b = t.mem_data;
        else if (t.wb_we && t.wb_rd != 0 && t.wb_rd == t.rt)   b = t.wb_data;
`endif
        ob = t.alu_src ? t.imm : b;
        case (t.alu_op)
            2'b00: r = a + ob;
            2'b01: r = a - ob;
            2'b11: r = a | ob;
            default: case (t.imm[5:0])
                6'h20: r = a + ob;
                6'h22: r = a - ob;
                6'h24: r = a & ob;
                6'h25: r = a | ob;
                6'h2A: r = ($signed(a) < $signed(ob)) ? 32'd1 : 32'd0;
                6'h18: r = a * ob;
                default: r = 32'd0;
            endcase
        endcase
        e.wb   = t.wb;
        e.m    = t.m;
        e.res  = r;
        e.wd   = b;
        e.dst  = t.reg_dst ? t.rd : t.rt;
        e.zero = (r == 32'd0);
        return e;
    endfunction

    function automatic instr_t rtype(logic [5:0] funct, logic [31:0] d1, logic [31:0] d2,
                                     logic [4:0] rs, logic [4:0] rt, logic [4:0] rd);
        instr_t t = '0;
        t.wb = 2'b11; t.m = 2'b01; t.alu_op = 2'b10; t.reg_dst = 1'b1;
        t.d1 = d1; t.d2 = d2; t.imm = {26'd0, funct};
        t.rs = rs; t.rt = rt; t.rd = rd;
        return t;
    endfunction

    task automatic drive(instr_t t);
        bus.EX_wb = t.wb;             bus.EX_m = t.m;
        bus.EX_alu_src = t.alu_src;   bus.EX_alu_op = t.alu_op;
        bus.EX_reg_dst = t.reg_dst;
        bus.EX_reg_data1 = t.d1;      bus.EX_reg_data2 = t.d2;
        bus.EX_sign_ext_imm = t.imm;
        bus.EX_instr_25_21 = t.rs;    bus.EX_instr_20_16 = t.rt;
        bus.EX_instr_15_11 = t.rd;
        bus.MEM_fwd_reg_write = t.mem_we; bus.WB_fwd_reg_write = t.wb_we;
        bus.MEM_fwd_rd = t.mem_rd;    bus.WB_fwd_rd = t.wb_rd;
        bus.MEM_fwd_data = t.mem_data; bus.WB_fwd_data = t.wb_data;
    endtask

    task automatic edge1();
        @(posedge clk);
        #1;
    endtask

    task automatic pin(string name, logic [31:0] r, logic z);
        lit_name = name; lit_res = r; lit_zero = z;
        lit_seq++;
    endtask

    // Present one instruction and advance until its result sits in EX/MEM.
    task automatic run(instr_t t);
        drive(t);
        if (!is_mul(t)) begin
            exp_stall = 1'b0;
            edge1();
            exp_q = model(t);
        end else begin
            exp_stall = 1'b1;
            for (int k = 1; k <= STEPS + 1; k++) begin
                edge1();
                exp_q = '0;
                exp_stall = (k <= STEPS);
            end
            edge1();
            exp_q = model(t);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            n_cmp++;
            if (bus.MEM_wb !== exp_q.wb || bus.MEM_m !== exp_q.m ||
                bus.MEM_alu_result !== exp_q.res || bus.MEM_write_data !== exp_q.wd ||
                bus.MEM_dst !== exp_q.dst || bus.MEM_zero !== exp_q.zero ||
                bus.ex_stall !== exp_stall) begin
                n_err++;
                $display("FAIL exmem t=%0t: got wb=%b m=%b res=%h wd=%h dst=%0d z=%b stall=%b; need wb=%b m=%b res=%h wd=%h dst=%0d z=%b stall=%b",
                         $time, bus.MEM_wb, bus.MEM_m, bus.MEM_alu_result, bus.MEM_write_data,
                         bus.MEM_dst, bus.MEM_zero, bus.ex_stall, exp_q.wb, exp_q.m, exp_q.res,
                         exp_q.wd, exp_q.dst, exp_q.zero, exp_stall);
            end
        end
        if (lit_seq != lit_done) begin
            lit_done = lit_seq;
            n_cmp++;
            if (bus.MEM_alu_result !== lit_res || bus.MEM_zero !== lit_zero) begin
                n_err++;
                $display("FAIL %s: got res=%h zero=%b; need res=%h zero=%b",
                         lit_name, bus.MEM_alu_result, bus.MEM_zero, lit_res, lit_zero);
            end
        end
    end

    initial begin
        instr_t t;
        instr_t nop;
        nop = rtype(6'h20, 32'd0, 32'd0, 5'd0, 5'd0, 5'd0);
        nop.wb = 2'b00; nop.m = 2'b00;

        // Reset with a live ADD on the inputs.
        drive(rtype(6'h20, 32'd7, 32'd5, 5'd1, 5'd2, 5'd9));
        edge1();
        chk_en = 1'b1;
        edge1();
        startin_n = 1'b1;

        run(rtype(6'h20, 32'd7, 32'd5, 5'd1, 5'd2, 5'd9));
        pin("add_7_5", 32'd12, 1'b0);

        t = rtype(6'h22, 32'd50, 32'd1, 5'd3, 5'd4, 5'd8);
        t.mem_we = 1'b1; t.mem_rd = 5'd3; t.mem_data = 32'd100;
        t.wb_we  = 1'b1; t.wb_rd  = 5'd3; t.wb_data  = 32'd200;
        run(t);
`ifdef EX_FORWARD_EN
        pin("fwd_mem_prio", 32'd99, 1'b0);
`else
        pin("fwd_mem_prio", 32'd49, 1'b0);
`endif
        t.mem_rd = 5'd0;
        run(t);
`ifdef EX_FORWARD_EN
        pin("fwd_wb", 32'd199, 1'b0);
`else
        pin("fwd_wb", 32'd49, 1'b0);
`endif

        // rt forwarded from WB into write data; rs=0 ignores a register-0 MEM source.
        t = rtype(6'h25, 32'd6, 32'd9, 5'd0, 5'd6, 5'd7);
        t.mem_we = 1'b1; t.mem_rd = 5'd0; t.mem_data = 32'hDEAD;
        t.wb_we  = 1'b1; t.wb_rd  = 5'd6; t.wb_data  = 32'h0F0;
        run(t);

        run(rtype(6'h2A, 32'hFFFF_FFFF, 32'd1, 5'd1, 5'd2, 5'd3));
        pin("slt_signed", 32'd1, 1'b0);
        run(rtype(6'h22, 32'd5, 32'd5, 5'd1, 5'd2, 5'd3));
        pin("sub_zero", 32'd0, 1'b1);
        run(rtype(6'h24, 32'hF0F0_1234, 32'h0FF0_FF00, 5'd1, 5'd2, 5'd4));
        run(rtype(6'h3F, 32'd11, 32'd22, 5'd1, 5'd2, 5'd5));
        pin("bad_funct", 32'd0, 1'b1);

        t = rtype(6'h05, 32'hFFFF_FFFF, 32'd0, 5'd1, 5'd12, 5'd13);
        t.alu_op = 2'b00; t.alu_src = 1'b1; t.reg_dst = 1'b0; t.imm = 32'd2;
        run(t);
        t.alu_op = 2'b01; t.imm = 32'hFFFF_FFFF; t.d1 = 32'd3;
        run(t);
        t.alu_op = 2'b11; t.imm = 32'h0000_8000; t.d1 = 32'h0000_0011;
        run(t);

        t = rtype(6'h18, 32'h0001_0001, 32'd3, 5'd1, 5'd2, 5'd10);
        t.wb = 2'b10; t.m = 2'b00;
        run(t);
        pin("mul_10001x3", 32'h0003_0003, 1'b0);
        // Back-to-back MUL, wrapping the product.
        run(rtype(6'h18, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd1, 5'd2, 5'd11));
        run(rtype(6'h18, 32'h8000_0000, 32'd2, 5'd1, 5'd2, 5'd12));
        pin("mul_wrap_zero", 32'd0, 1'b1);
        run(rtype(6'h20, 32'd1, 32'd2, 5'd1, 5'd2, 5'd3));

        // Reset at BUSY step 10: no product may ever reach EX/MEM.
        drive(rtype(6'h18, 32'd1234, 32'd5678, 5'd1, 5'd2, 5'd14));
        exp_stall = 1'b1;
        for (int k = 0; k <= 10; k++) begin
            edge1();
            exp_q = '0;
        end
        startin_n = 1'b0;
        edge1();
        exp_stall = 1'b0;
        startin_n = 1'b1;
        drive(nop);
        for (int k = 0; k < STEPS + 8; k++)
            run(nop);
        run(rtype(6'h20, 32'd40, 32'd2, 5'd1, 5'd2, 5'd15));
        pin("after_abort", 32'd42, 1'b0);

        edge1();
        chk_en = 1'b0;
        edge1();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/ex_stage_mul.md
Name: ex_stage_mul

Overview:
- Execute stage that consumes the ID/EX pipeline register outputs and produces the EX/MEM pipeline register.
- Contains the MEM/WB operand forwarding muxes, ALU control decode, single-cycle ALU and an iterative shift-add multiplier for R-type MUL.
- While a multiply is in progress it raises ex_stall. IF/ID/EX upstream registers hold while ex_stall is high; this stage inserts bubbles into EX/MEM.

Parameters:
- DATA_W, 32: datapath width.
- MUL_BITS, 1: multiplier bits retired per cycle; legal values 1, 2, 4. Step count is DATA_W/MUL_BITS.

Ports:
- clk  in  1  rising-edge clock.
- startin_n  in  1  synchronous active-low reset.
- EX_wb, EX_m  in  2 each  control from ID/EX, carried through to EX/MEM.
- EX_alu_src  in  1  1: operand B = EX_sign_ext_imm.
- EX_alu_op  in  2  00 add, 01 sub, 10 R-type (decode funct), 11 or.
- EX_reg_dst  in  1  1: destination = rd, 0: destination = rt.
- EX_reg_data1, EX_reg_data2, EX_sign_ext_imm  in  DATA_W each  operands; funct = EX_sign_ext_imm[5:0].
- EX_instr_25_21, EX_instr_20_16, EX_instr_15_11  in  5 each  rs, rt, rd.
- MEM_fwd_reg_write, WB_fwd_reg_write  in  1 each  write-enables of the instructions in MEM and WB.
- MEM_fwd_rd, WB_fwd_rd  in  5 each  destination registers of the instructions in MEM and WB.
- MEM_fwd_data, WB_fwd_data  in  DATA_W each  forwarding values.
- ex_stall  out  1  multiply busy; upstream must hold.
- MEM_wb, MEM_m  out  2 each  registered control.
- MEM_alu_result, MEM_write_data  out  DATA_W each  registered result and forwarded operand B.
- MEM_dst  out  5  registered destination register.
- MEM_zero  out  1  registered result==0.

Behaviour:
- Reset (startin_n=0 at an edge): all MEM_* outputs = 0, FSM = IDLE, counter = 0, ex_stall = 0. A reset during BUSY aborts the multiply; no result is written.
- Forwarding, operand A (rs):
  - If MEM_fwd_reg_write and MEM_fwd_rd!=0 and MEM_fwd_rd==rs: use MEM_fwd_data.
  - Else if the same test passes for WB: use WB_fwd_data.
  - Else: use EX_reg_data1.
  - MEM has priority over WB. Register 0 is never forwarded.
- Forwarding, operand B: same rules using rt, applied before the EX_alu_src mux. MEM_write_data always takes the forwarded rt value, never the immediate.
- ALU decode for alu_op=10: funct 0x20 add, 0x22 sub, 0x24 and, 0x25 or, 0x2A slt (signed), 0x18 mul. Any other funct gives result 0 with control passed through unchanged.
- Arithmetic wraps modulo 2^DATA_W. MUL writes the low DATA_W bits of the unsigned product.
- Non-mul instruction: one-cycle latency. EX/MEM captures result, control and destination at the next edge. ex_stall stays 0.
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - A MUL decoded in ID/EX raises ex_stall combinationally in the same cycle.
  - At the edge: latch forwarded A and B into internal multiplicand and multiplier registers, clear the accumulator, counter = 0, go to BUSY.
  - EX/MEM loads a bubble (wb=0, m=0, other fields 0).
- BUSY:
  - ex_stall = 1. Each edge retires MUL_BITS multiplier bits and increments the counter.
  - When the counter reaches DATA_W/MUL_BITS-1, go to DONE.
  - EX/MEM loads a bubble every cycle.
  - Operands are not re-sampled; forwarding sources may change while draining.
- DONE:
  - ex_stall = 0. EX/MEM captures the accumulator, the held wb/m control and the destination register. Go to IDLE.
  - With MUL_BITS=1: ex_stall is high for 33 cycles, and the product appears at MEM_alu_result 34 edges after the MUL was first presented.
- Back-to-back MUL: the second MUL is presented in the cycle after DONE and starts a fresh IDLE->BUSY sequence.
- MEM_zero reflects the captured result, including a captured mul result. It is 0 on bubbles.

Optional Feature:
- Macro EX_FORWARD_EN.
- Defined: forwarding muxes as described above.
- Undefined: operands come straight from EX_reg_data1/2, and the MEM_fwd_*/WB_fwd_* inputs are ignored (the software or upstream stall handles hazards). All other behaviour is unchanged.

Test Plan:
- Reset: hold startin_n=0 for 2 cycles with live inputs -> all MEM_* = 0 and ex_stall = 0.
- ADD: alu_op=10, funct=0x20, data1=7, data2=5, reg_dst=1, rd=9 -> next edge MEM_alu_result=12, MEM_dst=9, MEM_zero=0.
- Forward priority: rs=3, MEM_fwd_rd=3 with data 100, WB_fwd_rd=3 with data 200, SUB with data2=1 -> result 99. Same stimulus with MEM_fwd_rd=0 -> result 199.
- SLT signed: A=0xFFFFFFFF, B=1 -> result 1. SUB A=5, B=5 -> result 0 and MEM_zero=1.
- MUL: A=0x10001, B=3, MUL_BITS=1 -> ex_stall high 33 cycles, bubbles in EX/MEM, then MEM_alu_result=0x30003 with the mul's wb control.
- Reset mid-mul: drop startin_n at BUSY step 10 -> FSM IDLE, ex_stall=0, no product ever written.
